// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator-based min/max tracking stage.
package cmp_pkg;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMP_MIN,
        ST_CMP_MAX,
        ST_OUT
    } tracker_state_t;
endpackage

// File: rtl/eight_bit_comparator.sv
// Combinational unsigned magnitude comparator: exactly one of lt/eq/gt is set.
module eight_bit_comparator
    import cmp_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              lt,
    output logic              eq,
    output logic              gt
);
    assign lt = (A <  B);
    assign eq = (A == B);
    assign gt = (A >  B);
endmodule

// File: rtl/frame_minmax_tracker.sv
// Per-frame min/max/new-max tracker sharing one comparator across two compare cycles.
module frame_minmax_tracker
    import cmp_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_new_max
);
    tracker_state_t    state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  nm_q, nm_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_lt, cmp_eq, cmp_gt;

    // Operand B follows the state so one comparator serves both min and max checks.
    assign cmp_b = (state_q == ST_CMP_MAX) ? max_q : min_q;

    eight_bit_comparator u_cmp (
        .A  (sample_q),
        .B  (cmp_b),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign out_min     = min_q;
    assign out_max     = max_q;
    assign out_new_max = nm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            nm_q     <= '0;
            sample_q <= '0;
            min_q    <= '0;
            max_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            nm_q     <= nm_d;
            sample_q <= sample_d;
            min_q    <= min_d;
            max_q    <= max_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        nm_d     = nm_q;
        sample_d = sample_q;
        min_d    = min_q;
        max_d    = max_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sample_d = in_data;
                    count_d  = count_q + 1'b1;
                    if (count_q == '0) begin
                        // First sample seeds both extremes; nothing to compare against yet.
                        min_d   = in_data;
                        max_d   = in_data;
                        nm_d    = '0;
                        state_d = (FRAME_LEN == 1) ? ST_OUT : ST_IDLE;
                    end else begin
                        state_d = ST_CMP_MIN;
                    end
                end
            end
            ST_CMP_MIN: begin
                if (!cmp_eq && cmp_lt) min_d = sample_q;
                state_d = ST_CMP_MAX;
            end
            ST_CMP_MAX: begin
                if (!cmp_eq && cmp_gt) begin
                    max_d = sample_q;
                    nm_d  = nm_q + 1'b1;
                end
                state_d = (count_q == CNT_W'(FRAME_LEN)) ? ST_OUT : ST_IDLE;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Scoreboard bench: an 8-sample-frame instance and a single-sample-frame instance.
module tb_frame_minmax_tracker;
    typedef struct {
        logic [7:0] mn;
        logic [7:0] mx;
        int         nm;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv [2];
    logic       ir [2];
    logic       ov [2];
    logic       ordy [2];
    logic [7:0] id [2];
    logic [7:0] omin [2];
    logic [7:0] omax [2];
    logic [3:0] onm0;
    logic [0:0] onm1;
    logic       rnd_rdy = 1'b0;
    logic       rdy_force = 1'b1;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc [2];
    logic prev_ov [2];
    logic prev_hs [2];
    res_t q0 [$];
    res_t q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    frame_minmax_tracker #(.FRAME_LEN(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_min(omin[0]), .out_max(omax[0]), .out_new_max(onm0)
    );

    frame_minmax_tracker #(.FRAME_LEN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_min(omin[1]), .out_max(omax[1]), .out_new_max(onm1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic res_t golden(input logic [7:0] s [8]);
        res_t r;
        r.mn = s[0];
        r.mx = s[0];
        r.nm = 0;
        for (int i = 1; i < 8; i++) begin
            if (s[i] < r.mn) r.mn = s[i];
            if (s[i] > r.mx) begin
                r.mx = s[i];
                r.nm++;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] nm_of(input int d);
        return (d == 0) ? onm0 : {3'b000, onm1};
    endfunction

    // Random gap with toggling data, then present d; data is scrambled while not ready.
    task automatic send(input int sel, input logic [7:0] d, input int maxgap);
        int   g;
        logic acc;
        g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
        repeat (g) begin
            iv[sel] = 1'b0;
            id[sel] = 8'($urandom);
            @(posedge clk); #1;
        end
        iv[sel] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            acc = ir[sel];
            id[sel] = acc ? d : 8'($urandom);
            @(posedge clk); #1;
            if (acc) return;
        end
        chk("send_timeout", 1, 0);
    endtask

    task automatic send_frame(input logic [7:0] s [8], input int maxgap);
        q0.push_back(golden(s));
        for (int i = 0; i < 8; i++) send(0, s[i], maxgap);
        iv[0] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (q0.size() == 0 && q1.size() == 0) return;
            @(posedge clk); #1;
        end
        chk("drain_timeout", q0.size() + q1.size(), 0);
    endtask

    task automatic chk_reset_state(input int d);
        chk("rst_in_ready", ir[d], 1);
        chk("rst_out_valid", ov[d], 0);
        chk("rst_out_min", omin[d], 0);
        chk("rst_out_max", omax[d], 0);
        chk("rst_new_max", nm_of(d), 0);
    endtask

    always @(posedge clk) begin
        #2;
        ordy[0] = rnd_rdy ? 1'($urandom) : rdy_force;
    end

    always @(negedge clk) begin : mon
        res_t e;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                prev_ov[d] = 1'b0;
                prev_hs[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                chk("rdy_vld_excl", ir[d] & ov[d], 0);
                if (prev_hs[d]) chk("idle_after_out", {ov[d], ir[d]}, 2'b01);
                if (iv[d] && ir[d]) acc_cyc[d] = cyc;
                if (ov[d]) begin
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = (d == 0) ? q0[0] : q1[0];
                        chk(d == 0 ? "out_min" : "out_min_len1", omin[d], e.mn);
                        chk(d == 0 ? "out_max" : "out_max_len1", omax[d], e.mx);
                        chk(d == 0 ? "new_max" : "new_max_len1", nm_of(d), e.nm);
                        if (!prev_ov[d])
                            chk(d == 0 ? "latency" : "latency_len1", cyc - acc_cyc[d], (d == 0) ? 3 : 1);
                        if (ordy[d]) begin
                            if (d == 0) void'(q0.pop_front());
                            else        void'(q1.pop_front());
                        end
                    end
                end
                prev_ov[d] = ov[d];
                prev_hs[d] = ov[d] && ordy[d];
            end
        end
    end

    initial begin : main
        logic [7:0] fr [8];
        logic [7:0] d;
        iv[0] = 1'b0; iv[1] = 1'b0;
        id[0] = '0;   id[1] = '0;
        ordy[1] = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state(0);
        chk_reset_state(1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fr = '{8'd100, 8'd200, 8'd20, 8'd255, 8'd128, 8'd127, 8'd180, 8'd170};
        send_frame(fr, 0);
        fr = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100};
        send_frame(fr, 0);
        fr = '{8'd10, 8'd20, 8'd79, 8'd80, 8'd128, 8'd200, 8'd239, 8'd255};
        send_frame(fr, 0);
        fr = '{8'd239, 8'd150, 8'd55, 8'd29, 8'd20, 8'd10, 8'd1, 8'd0};
        send_frame(fr, 0);
        drain();

        // Output backpressure: result must hold with inputs blocked.
        rdy_force = 1'b0;
        fr = '{8'd7, 8'd9, 8'd3, 8'd9, 8'd12, 8'd2, 8'd12, 8'd5};
        send_frame(fr, 0);
        for (int i = 0; i < 20 && !ov[0]; i++) begin
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("bp_hold_valid", ov[0], 1);
        chk("bp_hold_ready", ir[0], 0);
        rdy_force = 1'b1;
        fr = '{8'd50, 8'd40, 8'd60, 8'd30, 8'd70, 8'd20, 8'd80, 8'd10};
        send_frame(fr, 0);
        drain();

        // Mid-frame reset discards the partial frame.
        fr = '{8'd5, 8'd250, 8'd3, 8'd251, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 4; i++) send(0, fr[i], 0);
        iv[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_state(0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fr = '{8'd79, 8'd80, 8'd81, 8'd82, 8'd83, 8'd84, 8'd85, 8'd86};
        send_frame(fr, 0);
        drain();

        // Random gaps, random output readiness, frequent ties.
        rnd_rdy = 1'b1;
        repeat (6) begin
            for (int i = 0; i < 8; i++)
                fr[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'(85 * $urandom_range(0, 3));
            send_frame(fr, 3);
        end
        drain();
        rnd_rdy = 1'b0;

        // Single-sample frames.
        repeat (10) begin
            d = 8'($urandom);
            q1.push_back('{mn: d, mx: d, nm: 0});
            send(1, d, 3);
        end
        iv[1] = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        chk("watchdog_timeout", 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
